i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- 7-bit-addressed I2C target (slave), the responder end of the team's I2C master.
- Watches SCL/SDA, detects START/STOP, and decodes the address byte plus R/W bit.
- ACKs its own address. Delivers written bytes to local logic and shifts out read bytes supplied by local logic.
- Runs entirely on sys_clk, oversampling the bus; it never drives SCL (no clock stretching).

Parameters:
- DEV_ADDR, 7'h50, target address compared against the first 7 received bits.
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronizers (minimum 2).

Ports:
- sys_clk  input  1  system clock; must be at least 8x the SCL frequency.
- rst  input  1  synchronous, active-low reset.
- scl_in  input  1  bus SCL level (asynchronous).
- sda_in  input  1  bus SDA level (asynchronous).
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release. Pad drives 0 when set.
- rx_data  output  8  last byte written by the master; held until the next rx_valid.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- tx_data  input  8  byte to return on a read; sampled on tx_req.
- tx_req  output  1  one-cycle pulse; tx_data is captured in the same cycle.
- busy  output  1  1 from an addressed START to STOP/NACK/mismatch return to IDLE.

Behaviour:

Reset (rst=0 at a sys_clk edge):
- state=IDLE; sda_oe=0; rx_data=8'h00; rx_valid=0; tx_req=0; busy=0.
- Bit counter and shift register cleared; synchronizer flops set to 1.
- Reset mid-transfer releases SDA on the next edge.

Input conditioning:
- scl_s/sda_s = synchronizer outputs; scl_p/sda_p = one-cycle-delayed copies.
- scl_rise = scl_s & ~scl_p; scl_fall = ~scl_s & scl_p.
- START = scl_s & sda_p & ~sda_s; STOP = scl_s & ~sda_p & sda_s.
- Latency from a pin edge to the detect cycle is SYNC_STAGES+1 sys_clk cycles. sda_oe changes on the cycle after scl_fall is detected.

Bit timing:
- Received bits are sampled (MSB first) on scl_rise.
- sda_oe changes only on scl_fall, so it is never changed while SCL is high.

States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
- IDLE: sda_oe=0. START -> ADDR, with bit counter=0.
- ADDR: shift 8 bits. On the scl_fall after the 8th scl_rise:
  - if bits[7:1]==DEV_ADDR -> ADDR_ACK, sda_oe=1, busy=1;
  - else -> IDLE (ignore the bus until the next START).
- ADDR_ACK: on the next scl_fall:
  - R/W=0 -> WR_DATA, sda_oe=0;
  - R/W=1 -> RD_DATA, pulse tx_req, load tx_data, drive ~tx_data[7] on sda_oe.
- WR_DATA: shift 8 bits. On the scl_fall after the 8th bit -> WR_ACK, sda_oe=1, rx_data=byte, rx_valid pulse (same cycle).
- WR_ACK: on the next scl_fall -> WR_DATA, sda_oe=0, counter=0. Unlimited multi-byte writes are supported.
- RD_DATA: on each scl_fall, present the next bit (sda_oe=~bit). After the 8th bit's scl_fall -> RD_ACK, sda_oe=0.
- RD_ACK: sample SDA on scl_rise.
  - 0 (ACK): on scl_fall, pulse tx_req, load the next byte, drive its MSB -> RD_DATA.
  - 1 (NACK): -> IDLE, busy=0, SDA released.

Global overrides (highest priority, any state except reset):
- STOP -> IDLE, sda_oe=0, busy=0.
- START (repeated) -> ADDR, counter=0, sda_oe=0, busy retained.
- Partial-byte STOP/START discards the partial byte; no rx_valid.

Simultaneous events: START/STOP detection takes precedence over scl edges in the same cycle; these cannot legally coincide since SCL is high.

Test Plan:
- Write 1 byte: START, 0xA0 (0x50,W), 0x3C, STOP -> ACK (SDA low) at both 9th clocks; rx_data=0x3C with one rx_valid pulse; busy 1 -> 0 after STOP.
- Address mismatch: START, 0xA2, 0x55 -> sda_oe stays 0 throughout; no rx_valid; busy=0.
- Read 2 bytes: START, 0xA1, tx_data=0x96 then 0x5A, master ACK then NACK -> SDA shows 10010110 then 01011010; exactly 2 tx_req pulses; IDLE after NACK.
- Repeated START: write 0xA0, 0x11, then Sr, 0xA1, read 1 byte with tx_data=0xE7 -> rx_data=0x11; then returns 0xE7 with no STOP in between.
- Abort: STOP after 4 data bits of a write -> no rx_valid, sda_oe=0, IDLE; the next full write of 0x81 is received correctly.
- Reset mid-ACK: assert rst while sda_oe=1 in ADDR_ACK -> sda_oe=0 and all outputs at reset values on the next edge.

Source files
------------

// File: rtl/i2c_target.sv
// 7-bit-addressed I2C target. Oversamples SCL/SDA on sys_clk, detects
// START/STOP, ACKs DEV_ADDR, hands written bytes to local logic and shifts
// out read bytes fetched via tx_req/tx_data. SCL is never driven.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_p, r_sda_p;
  logic [3:0]             r_cnt, w_cnt_nxt;
  logic [7:0]             r_shift, w_shift_nxt;
  logic [7:0]             r_rx_data, w_rxd_nxt;
  logic                   r_rx_valid, w_rxv_nxt;
  logic                   r_sda_oe, w_oe_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   w_tx_req;

  logic w_scl_s, w_sda_s, w_scl_rise, w_scl_fall, w_start, w_stop, w_addr_hit;

  assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl_s & ~r_scl_p;
  assign w_scl_fall = ~w_scl_s & r_scl_p;
  assign w_start    = w_scl_s & r_sda_p & ~w_sda_s;
  assign w_stop     = w_scl_s & ~r_sda_p & w_sda_s;
  assign w_addr_hit = (r_shift[7:1] == DEV_ADDR);

  // Input synchronizers plus one-cycle-delayed copies for edge detection;
  // reset to 1 so an idle bus produces no spurious edges.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_p    <= 1'b1;
      r_sda_p    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_p    <= w_scl_s;
      r_sda_p    <= w_sda_s;
    end
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; START/STOP override every bus-edge transition.
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop)       w_state_nxt = S_IDLE;
    else if (w_start) w_state_nxt = S_ADDR;
    else begin
      case (r_state)
        S_ADDR:     if (w_scl_fall && r_cnt == 4'd8)
                      w_state_nxt = w_addr_hit ? S_ADDR_ACK : S_IDLE;
        S_ADDR_ACK: if (w_scl_fall) w_state_nxt = r_shift[0] ? S_RD_DATA : S_WR_DATA;
        S_WR_DATA:  if (w_scl_fall && r_cnt == 4'd8) w_state_nxt = S_WR_ACK;
        S_WR_ACK:   if (w_scl_fall) w_state_nxt = S_WR_DATA;
        S_RD_DATA:  if (w_scl_fall && r_cnt == 4'd8) w_state_nxt = S_RD_ACK;
        S_RD_ACK: begin
          if (w_scl_rise && w_sda_s) w_state_nxt = S_IDLE;   // master NACK
          else if (w_scl_fall)       w_state_nxt = S_RD_DATA; // master ACK
        end
        default: ;
      endcase
    end
  end

  // Output/datapath next values. SDA only changes on scl_fall so the line
  // is stable while SCL is high. In read states the shifter's MSB is the
  // bit currently on the bus; r_cnt counts bits already presented.
  always_comb begin
    w_oe_nxt    = r_sda_oe;
    w_busy_nxt  = r_busy;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_rxd_nxt   = r_rx_data;
    w_rxv_nxt   = 1'b0;
    w_tx_req    = 1'b0;
    if (w_stop) begin
      w_oe_nxt   = 1'b0;
      w_busy_nxt = 1'b0;
      w_cnt_nxt  = 4'd0;
    end else if (w_start) begin
      w_oe_nxt  = 1'b0;
      w_cnt_nxt = 4'd0;
    end else begin
      case (r_state)
        S_ADDR, S_WR_DATA: begin
          if (w_scl_rise && r_cnt != 4'd8) begin
            w_shift_nxt = {r_shift[6:0], w_sda_s};
            w_cnt_nxt   = r_cnt + 4'd1;
          end
          if (w_scl_fall && r_cnt == 4'd8) begin
            if (r_state == S_ADDR) begin
              w_oe_nxt   = w_addr_hit;
              w_busy_nxt = w_addr_hit;
            end else begin
              w_oe_nxt  = 1'b1;
              w_rxd_nxt = r_shift;
              w_rxv_nxt = 1'b1;
            end
          end
        end
        S_ADDR_ACK: if (w_scl_fall) begin
          if (r_shift[0]) begin
            w_tx_req    = 1'b1;
            w_shift_nxt = tx_data;
            w_oe_nxt    = ~tx_data[7];
            w_cnt_nxt   = 4'd1;
          end else begin
            w_oe_nxt  = 1'b0;
            w_cnt_nxt = 4'd0;
          end
        end
        S_WR_ACK: if (w_scl_fall) begin
          w_oe_nxt  = 1'b0;
          w_cnt_nxt = 4'd0;
        end
        S_RD_DATA: if (w_scl_fall) begin
          if (r_cnt == 4'd8) w_oe_nxt = 1'b0;
          else begin
            w_oe_nxt    = ~r_shift[6];
            w_shift_nxt = {r_shift[6:0], 1'b0};
            w_cnt_nxt   = r_cnt + 4'd1;
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise && w_sda_s) begin
            w_busy_nxt = 1'b0;
            w_oe_nxt   = 1'b0;
          end else if (w_scl_fall) begin
            w_tx_req    = 1'b1;
            w_shift_nxt = tx_data;
            w_oe_nxt    = ~tx_data[7];
            w_cnt_nxt   = 4'd1;
          end
        end
        default: w_oe_nxt = 1'b0;
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_cnt      <= 4'd0;
      r_shift    <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else begin
      r_sda_oe   <= w_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_rx_data  <= w_rxd_nxt;
      r_rx_valid <= w_rxv_nxt;
    end
  end

  assign sda_oe   = r_sda_oe;
  assign busy     = r_busy;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_req   = w_tx_req;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged I2C master on an open-drain bus, with
// a transaction-level reference (address match, byte lists) for checking.
module tb_i2c_target;
  localparam int Q = 4;  // quarter SCL period in sys_clk cycles

  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       sda_oe, rx_valid, tx_req, busy;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_log[$];
  int         tx_cnt = 0;
  int         oe_cnt = 0;

  assign sda_bus = m_sda & ~sda_oe;

  always #5 sys_clk = ~sys_clk;

  i2c_target #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .scl_in  (m_scl),
    .sda_in  (sda_bus),
    .sda_oe  (sda_oe),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .busy    (busy)
  );

  // Passive monitor: logs delivered bytes, tx_req pulses, SDA-drive cycles.
  always @(negedge sys_clk) begin
    if (rx_valid) rx_log.push_back(rx_data);
    if (tx_req) tx_cnt = tx_cnt + 1;
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  task automatic wt(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_bit(input logic b, output logic got);
    m_sda = b; wt(Q);
    m_scl = 1'b1; wt(Q);
    got = sda_bus; wt(Q);
    m_scl = 1'b0; wt(Q);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wt(Q);
    m_scl = 1'b1; wt(2*Q);
    m_sda = 1'b0; wt(2*Q);
    m_scl = 1'b0; wt(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wt(Q);
    m_scl = 1'b1; wt(2*Q);
    m_sda = 1'b1; wt(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic g;
    for (int i = 7; i >= 0; i--) send_bit(b[i], g);
    send_bit(1'b1, g);
    ack = ~g;
  endtask

  task automatic read_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] b);
    logic g;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, g);
      b[i] = g;
    end
    tx_data = next_tx;
    send_bit(~mack, g);
  endtask

  task automatic test_reset();
    rst = 1'b0; wt(4);
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    n_checks++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL reset_tx_req got %b want 0", tx_req); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b1; wt(5);
  endtask

  task automatic test_write1();
    int rb; logic a;
    rb = rx_log.size();
    bus_start();
    write_byte(8'hA0, a);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL wr1_addr_ack got %b want 1", a); end
    write_byte(8'h3C, a);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL wr1_data_ack got %b want 1", a); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr1_busy got %b want 1", busy); end
    bus_stop();
    n_checks++; if (rx_log.size() - rb !== 1) begin n_fail++; $display("FAIL wr1_rx_count got %0d want 1", rx_log.size() - rb); end
    n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL wr1_rx_data got %h want 3c", rx_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr1_busy_after_stop got %b want 0", busy); end
  endtask

  task automatic test_mismatch();
    int rb, oe0; logic a;
    rb = rx_log.size(); oe0 = oe_cnt;
    bus_start();
    write_byte(8'hA2, a);
    n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL mm_addr_ack got %b want 0", a); end
    write_byte(8'h55, a);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mm_busy got %b want 0", busy); end
    bus_stop();
    n_checks++; if (oe_cnt !== oe0) begin n_fail++; $display("FAIL mm_sda_driven got %0d cycles want 0", oe_cnt - oe0); end
    n_checks++; if (rx_log.size() !== rb) begin n_fail++; $display("FAIL mm_rx_count got %0d want 0", rx_log.size() - rb); end
  endtask

  task automatic test_read2();
    int t0; logic a; logic [7:0] b0, b1;
    t0 = tx_cnt;
    tx_data = 8'h96;
    bus_start();
    write_byte(8'hA1, a);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL rd2_addr_ack got %b want 1", a); end
    read_byte(1'b1, 8'h5A, b0);
    read_byte(1'b0, 8'h00, b1);
    n_checks++; if (b0 !== 8'h96) begin n_fail++; $display("FAIL rd2_byte0 got %h want 96", b0); end
    n_checks++; if (b1 !== 8'h5A) begin n_fail++; $display("FAIL rd2_byte1 got %h want 5a", b1); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd2_busy_after_nack got %b want 0", busy); end
    n_checks++; if (tx_cnt - t0 !== 2) begin n_fail++; $display("FAIL rd2_tx_req_count got %0d want 2", tx_cnt - t0); end
    bus_stop();
  endtask

  task automatic test_rep_start();
    int rb; logic a; logic [7:0] b;
    rb = rx_log.size();
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h11, a);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL rs_data_ack got %b want 1", a); end
    tx_data = 8'hE7;
    bus_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rs_busy_retained got %b want 1", busy); end
    write_byte(8'hA1, a);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL rs_addr_ack got %b want 1", a); end
    read_byte(1'b0, 8'h00, b);
    n_checks++; if (b !== 8'hE7) begin n_fail++; $display("FAIL rs_read got %h want e7", b); end
    n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL rs_rx_data got %h want 11", rx_data); end
    n_checks++; if (rx_log.size() - rb !== 1) begin n_fail++; $display("FAIL rs_rx_count got %0d want 1", rx_log.size() - rb); end
    bus_stop();
  endtask

  task automatic test_abort();
    int rb; logic a, g;
    rb = rx_log.size();
    bus_start();
    write_byte(8'hA0, a);
    send_bit(1'b1, g); send_bit(1'b0, g); send_bit(1'b1, g); send_bit(1'b1, g);
    bus_stop();
    n_checks++; if (rx_log.size() !== rb) begin n_fail++; $display("FAIL ab_rx_count got %0d want 0", rx_log.size() - rb); end
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL ab_sda_oe got %b want 0", sda_oe); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ab_busy got %b want 0", busy); end
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h81, a);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL ab_next_ack got %b want 1", a); end
    bus_stop();
    n_checks++; if (rx_data !== 8'h81) begin n_fail++; $display("FAIL ab_next_rx_data got %h want 81", rx_data); end
    n_checks++; if (rx_log.size() - rb !== 1) begin n_fail++; $display("FAIL ab_next_rx_count got %0d want 1", rx_log.size() - rb); end
  endtask

  task automatic test_reset_mid_ack();
    logic g; logic [7:0] addr; int waited;
    addr = 8'hA0;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(addr[i], g);
    waited = 0;
    while (sda_oe !== 1'b1 && waited < 20) begin wt(1); waited++; end
    n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rma_ack_drive got %b want 1 within 20 cycles", sda_oe); end
    rst = 1'b0;
    @(posedge sys_clk); #1;
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rma_sda_oe got %b want 0", sda_oe); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rma_busy got %b want 0", busy); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rma_rx_data got %h want 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0 || tx_req !== 1'b0) begin n_fail++; $display("FAIL rma_pulses got %b%b want 00", rx_valid, tx_req); end
    @(negedge sys_clk);
    m_sda = 1'b1; m_scl = 1'b1; wt(4);
    rst = 1'b1; wt(8);
  endtask

  // Random transactions against a transaction-level model: the target ACKs
  // only address 0x50, writes deliver each byte in order, reads return the
  // supplied bytes with one tx_req per byte.
  task automatic test_random();
    logic match, rw, a; logic [6:0] a7; int n, rb, t0;
    logic [7:0] d[4]; logic [7:0] b;
    for (int t = 0; t < 24; t++) begin
      match = 1'($urandom_range(0, 1));
      rw    = 1'($urandom_range(0, 1));
      n     = $urandom_range(1, 4);
      a7    = match ? 7'h50 : 7'h50 + 7'($urandom_range(1, 127));
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
      rb = rx_log.size(); t0 = tx_cnt;
      tx_data = d[0];
      bus_start();
      write_byte({a7, rw}, a);
      n_checks++; if (a !== match) begin n_fail++; $display("FAIL rnd%0d_addr_ack addr %h got %b want %b", t, a7, a, match); end
      if (!match) begin
        bus_stop();
        n_checks++; if (rx_log.size() !== rb || tx_cnt !== t0 || busy !== 1'b0) begin
          n_fail++; $display("FAIL rnd%0d_ignored rx %0d tx %0d busy %b want 0 0 0", t, rx_log.size() - rb, tx_cnt - t0, busy);
        end
      end else if (!rw) begin
        for (int k = 0; k < n; k++) begin
          write_byte(d[k], a);
          n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_wr_ack%0d got %b want 1", t, k, a); end
        end
        bus_stop();
        n_checks++; if (rx_log.size() - rb !== n) begin n_fail++; $display("FAIL rnd%0d_rx_count got %0d want %0d", t, rx_log.size() - rb, n); end
        for (int k = 0; k < n && rb + k < rx_log.size(); k++) begin
          n_checks++; if (rx_log[rb+k] !== d[k]) begin n_fail++; $display("FAIL rnd%0d_rx%0d got %h want %h", t, k, rx_log[rb+k], d[k]); end
        end
      end else begin
        for (int k = 0; k < n; k++) begin
          read_byte(k < n - 1, (k < 3) ? d[k+1] : 8'h00, b);
          n_checks++; if (b !== d[k]) begin n_fail++; $display("FAIL rnd%0d_rd%0d got %h want %h", t, k, b, d[k]); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_busy_after_nack got %b want 0", t, busy); end
        bus_stop();
        n_checks++; if (tx_cnt - t0 !== n) begin n_fail++; $display("FAIL rnd%0d_tx_req_count got %0d want %0d", t, tx_cnt - t0, n); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write1();
    test_mismatch();
    test_read2();
    test_rep_start();
    test_abort();
    test_reset_mid_ack();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
